// File: rtl/l2_refill_arbiter_if.sv
// l2_refill_arbiter_if: Icache/Dcache/L2 handshake bundle for the L2 refill arbiter
//  slave  : arbiter view (takes cache requests and L2 responses, drives grants, L2 requests, refills)
//  master : environment view (caches and L2 side)
interface l2_refill_arbiter_if #(
    parameter int ADDR_W = 34,
    parameter int LINE_W = 256
);
    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid;
    logic              ic_resp_ready;
    logic [LINE_W-1:0] ic_resp_line;
    logic              dc_req_valid;
    logic              dc_req_ready;
    logic [ADDR_W-1:0] dc_req_addr;
    logic              dc_req_we;
    logic [LINE_W-1:0] dc_req_wline;
    logic              dc_resp_valid;
    logic              dc_resp_ready;
    logic [LINE_W-1:0] dc_resp_line;
    logic              l2_req_valid;
    logic              l2_req_ready;
    logic [ADDR_W-1:0] l2_req_addr;
    logic              l2_req_we;
    logic [LINE_W-1:0] l2_req_wline;
    logic              l2_resp_valid;
    logic              l2_resp_ready;
    logic [LINE_W-1:0] l2_resp_line;

    modport slave (
        input  ic_req_valid, ic_req_addr, ic_resp_ready,
        input  dc_req_valid, dc_req_addr, dc_req_we, dc_req_wline, dc_resp_ready,
        input  l2_req_ready, l2_resp_valid, l2_resp_line,
        output ic_req_ready, ic_resp_valid, ic_resp_line,
        output dc_req_ready, dc_resp_valid, dc_resp_line,
        output l2_req_valid, l2_req_addr, l2_req_we, l2_req_wline, l2_resp_ready
    );

    modport master (
        output ic_req_valid, ic_req_addr, ic_resp_ready,
        output dc_req_valid, dc_req_addr, dc_req_we, dc_req_wline, dc_resp_ready,
        output l2_req_ready, l2_resp_valid, l2_resp_line,
        input  ic_req_ready, ic_resp_valid, ic_resp_line,
        input  dc_req_ready, dc_resp_valid, dc_resp_line,
        input  l2_req_valid, l2_req_addr, l2_req_we, l2_req_wline, l2_resp_ready
    );
endinterface

// File: rtl/l2_refill_arbiter.sv
// l2_refill_arbiter: round-robin sharing of one L2 port between Icache and Dcache, one transaction in flight
//  clk, rst     : clock, synchronous active-high reset
//  bus          : cache request/response and L2 request/response handshakes (slave view)
//  busy_o       : a transaction is in progress
//  owner_dc_o   : current/last granted owner, 0 Icache, 1 Dcache
module l2_refill_arbiter #(
    parameter int ADDR_W = 34,
    parameter int LINE_W = 256,
    parameter int OFS_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    l2_refill_arbiter_if.slave    bus,
    output logic                  busy_o,
    output logic                  owner_dc_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFS_W){1'b1}}, {OFS_W{1'b0}}};

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              grant, grant_dc;

    // Dcache wins when alone, or on a tie when the Icache had the previous grant
    assign grant_dc = bus.dc_req_valid && (!bus.ic_req_valid || !last_grant_q);
    assign grant    = !rst && state_q == IDLE && (bus.ic_req_valid || bus.dc_req_valid);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wline_d      = wline_q;
        line_d       = line_q;
        case (state_q)
            IDLE: if (grant) begin
                owner_d      = grant_dc;
                last_grant_d = grant_dc;
                addr_d       = (grant_dc ? bus.dc_req_addr : bus.ic_req_addr) & LINE_MASK;
                we_d         = grant_dc && bus.dc_req_we;
                wline_d      = grant_dc ? bus.dc_req_wline : '0;
                state_d      = REQ;
            end
            REQ:  state_d = bus.l2_req_ready ? WAIT : REQ;
            WAIT: if (bus.l2_resp_valid) begin
                line_d  = we_q ? '0 : bus.l2_resp_line;
                state_d = RESP;
            end
            RESP: state_d = (owner_q ? bus.dc_resp_ready : bus.ic_resp_ready) ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wline_q      <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wline_q      <= wline_d;
            line_q       <= line_d;
        end
    end

    assign bus.ic_req_ready  = grant && !grant_dc;
    assign bus.dc_req_ready  = grant && grant_dc;
    assign bus.l2_req_valid  = state_q == REQ;
    assign bus.l2_req_addr   = addr_q;
    assign bus.l2_req_we     = we_q;
    assign bus.l2_req_wline  = wline_q;
    assign bus.l2_resp_ready = state_q == WAIT;
    assign bus.ic_resp_valid = state_q == RESP && !owner_q;
    assign bus.dc_resp_valid = state_q == RESP && owner_q;
    assign bus.ic_resp_line  = bus.ic_resp_valid ? line_q : '0;
    assign bus.dc_resp_line  = bus.dc_resp_valid ? line_q : '0;
    assign busy_o            = state_q != IDLE;
    assign owner_dc_o        = owner_q;
endmodule

// File: tb/tb_l2_refill_arbiter.sv
// tb_l2_refill_arbiter: directed self-checking bench for l2_refill_arbiter
module tb_l2_refill_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, owner_dc;
    int checks = 0;
    int errors = 0;

    localparam logic [255:0] LINE_A = {8{32'h1111_0001}};
    localparam logic [255:0] LINE_B = {8{32'h2222_0002}};
    localparam logic [255:0] LINE_C = {8{32'h3333_0003}};
    localparam logic [255:0] LINE_W = {32{8'hA5}};

    l2_refill_arbiter_if bus ();

    l2_refill_arbiter dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy_o(busy),
        .owner_dc_o(owner_dc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.ic_req_valid  = 0; bus.ic_req_addr = '0; bus.ic_resp_ready = 0;
        bus.dc_req_valid  = 0; bus.dc_req_addr = '0; bus.dc_req_we = 0; bus.dc_req_wline = '0;
        bus.dc_resp_ready = 0; bus.l2_req_ready = 0; bus.l2_resp_valid = 0; bus.l2_resp_line = '0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1; tick(); tick(); rst = 0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (owner_dc !== 1'b0) begin errors++; $display("FAIL rst_owner got %b exp 0", owner_dc); end
        checks++; if (bus.l2_req_valid !== 1'b0) begin errors++; $display("FAIL rst_l2_valid got %b exp 0", bus.l2_req_valid); end
        checks++; if (bus.l2_resp_ready !== 1'b0) begin errors++; $display("FAIL rst_l2_resp_ready got %b exp 0", bus.l2_resp_ready); end
        checks++; if ({bus.ic_req_ready, bus.dc_req_ready, bus.ic_resp_valid, bus.dc_resp_valid} !== 4'b0) begin errors++; $display("FAIL rst_handshakes got %b exp 0000", {bus.ic_req_ready, bus.dc_req_ready, bus.ic_resp_valid, bus.dc_resp_valid}); end
        checks++; if (bus.l2_req_addr !== 34'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus.l2_req_addr); end
    endtask

    task automatic test_ic_only;
        bus.ic_req_valid = 1; bus.ic_req_addr = 34'h2_0000_1234;
        bus.l2_req_ready = 1; bus.l2_resp_valid = 1; bus.l2_resp_line = LINE_A; #1;
        checks++; if ({bus.ic_req_ready, bus.dc_req_ready} !== 2'b10) begin errors++; $display("FAIL ic_grant got %b exp 10", {bus.ic_req_ready, bus.dc_req_ready}); end
        tick(); bus.ic_req_valid = 0; #1;
        checks++; if (bus.l2_req_valid !== 1'b1) begin errors++; $display("FAIL ic_l2_valid got %b exp 1", bus.l2_req_valid); end
        checks++; if (bus.l2_req_addr !== 34'h2_0000_1220) begin errors++; $display("FAIL ic_l2_addr got %h exp 200001220", bus.l2_req_addr); end
        checks++; if (bus.l2_req_we !== 1'b0) begin errors++; $display("FAIL ic_l2_we got %b exp 0", bus.l2_req_we); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ic_busy got %b exp 1", busy); end
        checks++; if (bus.ic_req_ready !== 1'b0) begin errors++; $display("FAIL ic_ready_pulse got %b exp 0", bus.ic_req_ready); end
        tick();
        checks++; if (bus.l2_resp_ready !== 1'b1) begin errors++; $display("FAIL ic_wait_ready got %b exp 1", bus.l2_resp_ready); end
        checks++; if (bus.ic_resp_valid !== 1'b0) begin errors++; $display("FAIL ic_resp_early got %b exp 0", bus.ic_resp_valid); end
        tick();
        checks++; if (bus.ic_resp_valid !== 1'b1) begin errors++; $display("FAIL ic_resp_valid got %b exp 1", bus.ic_resp_valid); end
        checks++; if (bus.ic_resp_line !== LINE_A) begin errors++; $display("FAIL ic_resp_line got %h exp %h", bus.ic_resp_line, LINE_A); end
        checks++; if (bus.dc_resp_valid !== 1'b0) begin errors++; $display("FAIL ic_dc_resp got %b exp 0", bus.dc_resp_valid); end
        bus.ic_resp_ready = 1; tick(); bus.ic_resp_ready = 0; #1;
        checks++; if ({busy, bus.ic_resp_valid} !== 2'b00) begin errors++; $display("FAIL ic_done got %b exp 00", {busy, bus.ic_resp_valid}); end
        checks++; if (owner_dc !== 1'b0) begin errors++; $display("FAIL ic_owner_idle got %b exp 0", owner_dc); end
    endtask

    task automatic test_tie;
        rst = 1; tick(); rst = 0;
        bus.ic_req_addr = 34'h0_0000_0040; bus.dc_req_addr = 34'h0_0000_0080;
        bus.l2_req_ready = 1; bus.l2_resp_valid = 1; bus.l2_resp_line = LINE_B;
        bus.ic_resp_ready = 1; bus.dc_resp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            logic exp_dc;
            exp_dc = k[0];
            bus.ic_req_valid = 1; bus.dc_req_valid = 1; #1;
            checks++; if ({bus.ic_req_ready, bus.dc_req_ready} !== {!exp_dc, exp_dc}) begin errors++; $display("FAIL tie_grant%0d got %b exp %b", k, {bus.ic_req_ready, bus.dc_req_ready}, {!exp_dc, exp_dc}); end
            tick(); bus.ic_req_valid = 0; bus.dc_req_valid = 0; #1;
            checks++; if (owner_dc !== exp_dc) begin errors++; $display("FAIL tie_owner%0d got %b exp %b", k, owner_dc, exp_dc); end
            checks++; if (bus.l2_req_addr !== (exp_dc ? 34'h80 : 34'h40)) begin errors++; $display("FAIL tie_addr%0d got %h exp %h", k, bus.l2_req_addr, exp_dc ? 34'h80 : 34'h40); end
            tick(); tick(); tick();
        end
        bus.ic_resp_ready = 0; bus.dc_resp_ready = 0;
    endtask

    task automatic test_writeback;
        bus.dc_req_valid = 1; bus.dc_req_we = 1; bus.dc_req_wline = LINE_W; bus.dc_req_addr = 34'h1_2345_6789;
        bus.l2_req_ready = 1; bus.l2_resp_valid = 1; bus.l2_resp_line = LINE_C; #1;
        checks++; if ({bus.ic_req_ready, bus.dc_req_ready} !== 2'b01) begin errors++; $display("FAIL wb_grant got %b exp 01", {bus.ic_req_ready, bus.dc_req_ready}); end
        tick(); bus.dc_req_valid = 0; bus.dc_req_we = 0; bus.dc_req_wline = '0; #1;
        checks++; if (bus.l2_req_we !== 1'b1) begin errors++; $display("FAIL wb_we got %b exp 1", bus.l2_req_we); end
        checks++; if (bus.l2_req_wline !== LINE_W) begin errors++; $display("FAIL wb_wline got %h exp %h", bus.l2_req_wline, LINE_W); end
        checks++; if (bus.l2_req_addr !== 34'h1_2345_6780) begin errors++; $display("FAIL wb_addr got %h exp 123456780", bus.l2_req_addr); end
        tick(); tick();
        checks++; if (bus.dc_resp_valid !== 1'b1) begin errors++; $display("FAIL wb_resp_valid got %b exp 1", bus.dc_resp_valid); end
        checks++; if (bus.dc_resp_line !== 256'h0) begin errors++; $display("FAIL wb_resp_line got %h exp 0", bus.dc_resp_line); end
        checks++; if (bus.ic_resp_valid !== 1'b0) begin errors++; $display("FAIL wb_ic_resp got %b exp 0", bus.ic_resp_valid); end
        bus.dc_resp_ready = 1; tick(); bus.dc_resp_ready = 0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wb_done got %b exp 0", busy); end
    endtask

    task automatic test_l2_stall;
        int bad;
        bad = 0;
        bus.ic_req_valid = 1; bus.ic_req_addr = 34'h3_FFFF_FFFF;
        bus.l2_req_ready = 0; bus.l2_resp_valid = 0; bus.l2_resp_line = LINE_C;
        tick(); bus.ic_req_valid = 0;
        for (int c = 0; c < 10; c++) begin
            bus.l2_resp_valid = (c == 5); #1;
            if (!bus.l2_req_valid || bus.l2_req_addr !== 34'h3_FFFF_FFE0 || bus.l2_resp_ready || !busy) bad++;
            tick();
        end
        bus.l2_resp_valid = 0; #1;
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_stable got %0d bad cycles exp 0", bad); end
        checks++; if ({bus.l2_req_valid, bus.l2_resp_ready, bus.ic_resp_valid} !== 3'b100) begin errors++; $display("FAIL stall_still_req got %b exp 100", {bus.l2_req_valid, bus.l2_resp_ready, bus.ic_resp_valid}); end
        bus.l2_req_ready = 1; tick(); bus.l2_req_ready = 0;
        checks++; if (bus.l2_resp_ready !== 1'b1) begin errors++; $display("FAIL stall_wait got %b exp 1", bus.l2_resp_ready); end
        bus.l2_resp_valid = 1; bus.l2_resp_line = LINE_A; tick(); bus.l2_resp_valid = 0;
        checks++; if (bus.ic_resp_line !== LINE_A) begin errors++; $display("FAIL stall_line got %h exp %h", bus.ic_resp_line, LINE_A); end
        bus.ic_resp_ready = 1; tick(); bus.ic_resp_ready = 0;
    endtask

    task automatic test_resp_hold;
        int bad;
        bad = 0;
        bus.ic_req_valid = 1; bus.ic_req_addr = 34'h0_0000_1000;
        bus.l2_req_ready = 1; bus.l2_resp_valid = 1; bus.l2_resp_line = LINE_B;
        tick(); bus.ic_req_valid = 0; tick(); tick();
        bus.l2_resp_line = LINE_C;
        bus.dc_req_valid = 1; bus.dc_req_addr = 34'h0_0000_2010;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (!bus.ic_resp_valid || bus.ic_resp_line !== LINE_B || bus.dc_req_ready) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_resp got %0d bad cycles exp 0", bad); end
        bus.ic_resp_ready = 1; #1;
        checks++; if (bus.dc_req_ready !== 1'b0) begin errors++; $display("FAIL hold_no_bypass got %b exp 0", bus.dc_req_ready); end
        tick(); bus.ic_resp_ready = 0; #1;
        checks++; if (bus.dc_req_ready !== 1'b1) begin errors++; $display("FAIL hold_dc_grant got %b exp 1", bus.dc_req_ready); end
        tick(); bus.dc_req_valid = 0; tick(); tick();
        checks++; if ({bus.dc_resp_valid, bus.ic_resp_valid} !== 2'b10) begin errors++; $display("FAIL hold_dc_resp got %b exp 10", {bus.dc_resp_valid, bus.ic_resp_valid}); end
        checks++; if (bus.dc_resp_line !== LINE_C) begin errors++; $display("FAIL hold_dc_line got %h exp %h", bus.dc_resp_line, LINE_C); end
        bus.dc_resp_ready = 1; tick(); bus.dc_resp_ready = 0;
    endtask

    task automatic test_reset_wait;
        bus.ic_req_valid = 1; bus.ic_req_addr = 34'h0_0ABC_DEF0;
        bus.l2_req_ready = 1; bus.l2_resp_valid = 0;
        tick(); bus.ic_req_valid = 0; tick();
        checks++; if (bus.l2_resp_ready !== 1'b1) begin errors++; $display("FAIL rw_in_wait got %b exp 1", bus.l2_resp_ready); end
        rst = 1; tick(); rst = 0; #1;
        checks++; if ({busy, bus.l2_req_valid, bus.l2_resp_ready, bus.ic_resp_valid, bus.dc_resp_valid} !== 5'b0) begin errors++; $display("FAIL rw_outputs got %b exp 00000", {busy, bus.l2_req_valid, bus.l2_resp_ready, bus.ic_resp_valid, bus.dc_resp_valid}); end
        checks++; if ({bus.l2_req_addr, owner_dc} !== 35'h0) begin errors++; $display("FAIL rw_regs got %h exp 0", {bus.l2_req_addr, owner_dc}); end
        bus.ic_req_valid = 1; bus.ic_req_addr = 34'h0_0000_0555; bus.l2_resp_valid = 1; bus.l2_resp_line = LINE_C; #1;
        checks++; if (bus.ic_req_ready !== 1'b1) begin errors++; $display("FAIL rw_regrant got %b exp 1", bus.ic_req_ready); end
        tick(); bus.ic_req_valid = 0; #1;
        checks++; if (bus.l2_req_addr !== 34'h0_0000_0540) begin errors++; $display("FAIL rw_addr got %h exp 540", bus.l2_req_addr); end
        tick(); tick();
        checks++; if ({bus.ic_resp_valid, bus.ic_resp_line} !== {1'b1, LINE_C}) begin errors++; $display("FAIL rw_resp got %b/%h exp 1/%h", bus.ic_resp_valid, bus.ic_resp_line, LINE_C); end
        bus.ic_resp_ready = 1; tick(); bus.ic_resp_ready = 0;
    endtask

    initial begin
        test_reset();
        test_ic_only();
        test_tie();
        test_writeback();
        test_l2_stall();
        test_resp_hold();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
